// File: rtl/arbiter_nq.sv
// rtl/arbiter_nq.sv - N-requester quota-limited round-robin arbiter
//
// Purpose:
//   Grants one of N requesters at a time. While others wait, a holder keeps
//   the grant for up to its per-requester runtime quota of consecutive cycles.
//   The grant then rotates round-robin. A per-requester usage counter rises
//   while granted and decays while not granted. Recent use therefore shortens
//   the next window.
//
// Optional feature:
//   ARB_LOCK_EN - adds the lock input. It pins the current holder while that
//   holder keeps requesting.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset
//   req        in   N   request vector, bit i = requester i
//   quota      in   N*CW packed quotas, field i = quota[i*CW +: CW], 0 acts as 1
//   lock       in   1   hold current grant (ARB_LOCK_EN builds only)
//   gnt        out  N   registered one-hot grant or zero
//   gnt_valid  out  1   registered, high when gnt != 0
//   gnt_id     out  IW  registered holder index, keeps last value when idle

module arbiter_nq #(
    parameter int N  = 4,
    parameter int CW = 5,
    parameter int IW = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req,
    input  logic [N*CW-1:0] quota,
`ifdef ARB_LOCK_EN
    input  logic            lock,
`endif
    output logic [N-1:0]    gnt,
    output logic            gnt_valid,
    output logic [IW-1:0]   gnt_id
);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    state_t          r_state;
    logic [N-1:0]    r_gnt;
    logic            r_gnt_valid;
    logic [IW-1:0]   r_gnt_id;     // doubles as the holder index in S_GRANT
    logic [IW-1:0]   r_ptr;
    logic [CW-1:0]   r_cnt [N];

    state_t          w_state_nxt;
    logic [IW-1:0]   w_id_nxt;
    logic            w_change;
    logic [N-1:0]    w_gnt_nxt;
    logic            w_valid_nxt;
    logic [IW-1:0]   w_ptr_nxt;
    logic [CW-1:0]   w_cnt_nxt [N];
    logic [CW-1:0]   w_qe [N];
    logic [CW-1:0]   w_cnt_h;
    logic [CW-1:0]   w_qe_h;
    logic [N-1:0]    w_hold_mask;
    logic [IW-1:0]   w_start_h;
    logic            w_ptr_ok;
    logic [IW-1:0]   w_ptr_id;
    logic            w_oth_ok;
    logic [IW-1:0]   w_oth_id;
    logic            w_lock;

`ifdef ARB_LOCK_EN
    assign w_lock = lock;
`else
    assign w_lock = 1'b0;
`endif

    // Round-robin search. Candidates are scanned from the farthest distance
    // down to distance 0, so the nearest requester from start is written last
    // and wins.
    function automatic logic [IW:0] rr_pick(input logic [N-1:0] mask,
                                            input logic [IW-1:0] start);
        logic          found;
        logic [IW-1:0] id;
        int            j;
        found = 1'b0;
        id    = '0;
        for (int k = N - 1; k >= 0; k--) begin
            j = (int'(start) + k) % N;
            if (mask[IW'(j)]) begin
                found = 1'b1;
                id    = IW'(j);
            end
        end
        return {found, id};
    endfunction

    function automatic logic [N-1:0] onehot(input logic [IW-1:0] idx);
        return {{(N-1){1'b0}}, 1'b1} << idx;
    endfunction

    // Effective quotas. A zero field means one cycle.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            w_qe[i] = (quota[i*CW +: CW] == '0) ? CW'(1) : quota[i*CW +: CW];
        end
    end

    // Holder's counter and quota, selected by the current holder index.
    always_comb begin
        w_cnt_h = '0;
        w_qe_h  = CW'(1);
        for (int i = 0; i < N; i++) begin
            if (IW'(i) == r_gnt_id) begin
                w_cnt_h = r_cnt[i];
                w_qe_h  = w_qe[i];
            end
        end
    end

    assign w_hold_mask = onehot(r_gnt_id);
    assign w_start_h   = (r_gnt_id == IW'(N - 1)) ? '0 : r_gnt_id + 1'b1;

    always_comb begin
        {w_ptr_ok, w_ptr_id} = rr_pick(req, r_ptr);
        // Excluding the holder also covers the dropped-request case, because
        // req[h] is already 0 there.
        {w_oth_ok, w_oth_id} = rr_pick(req & ~w_hold_mask, w_start_h);
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        w_id_nxt    = r_gnt_id;
        w_change    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_ptr_ok) begin
                    w_state_nxt = S_GRANT;
                    w_id_nxt    = w_ptr_id;
                    w_change    = 1'b1;
                end
            end
            S_GRANT: begin
                if (!req[r_gnt_id]) begin
                    if (w_oth_ok) begin
                        w_id_nxt = w_oth_id;
                        w_change = 1'b1;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end else if (w_oth_ok && !w_lock && (w_cnt_h >= w_qe_h - 1'b1)) begin
                    // The counter reaches its quota on this same edge. Yield
                    // now so the holder gets exactly qe cycles from zero use.
                    w_id_nxt = w_oth_id;
                    w_change = 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Registered-output values derived from the next state
    always_comb begin
        w_valid_nxt = (w_state_nxt == S_GRANT);
        w_gnt_nxt   = w_valid_nxt ? onehot(w_id_nxt) : '0;
        w_ptr_nxt   = (w_id_nxt == IW'(N - 1)) ? '0 : w_id_nxt + 1'b1;
    end

    // Usage counters saturate at 0 and at the effective quota.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            w_cnt_nxt[i] = r_cnt[i];
            if (r_gnt[i] && (r_cnt[i] < w_qe[i])) begin
                w_cnt_nxt[i] = r_cnt[i] + 1'b1;
            end else if (!r_gnt[i] && (r_cnt[i] != '0)) begin
                w_cnt_nxt[i] = r_cnt[i] - 1'b1;
            end
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_gnt       <= '0;
            r_gnt_valid <= 1'b0;
            r_gnt_id    <= '0;
            r_ptr       <= '0;
            for (int i = 0; i < N; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_state     <= w_state_nxt;
            r_gnt       <= w_gnt_nxt;
            r_gnt_valid <= w_valid_nxt;
            r_gnt_id    <= w_id_nxt;
            if (w_change) begin
                r_ptr <= w_ptr_nxt;
            end
            for (int i = 0; i < N; i++) begin
                r_cnt[i] <= w_cnt_nxt[i];
            end
        end
    end

    assign gnt       = r_gnt;
    assign gnt_valid = r_gnt_valid;
    assign gnt_id    = r_gnt_id;

endmodule

// File: tb/tb_arbiter_nq.sv
// tb/tb_arbiter_nq.sv - self-checking bench for arbiter_nq

module tb_arbiter_nq;

    localparam int N  = 4;
    localparam int CW = 5;
    localparam int IW = 2;

    typedef struct {
        string           tag;
        logic            rst;
        logic [N-1:0]    req;
        logic [N*CW-1:0] quota;
        logic            lock;
        logic [N-1:0]    g;
        logic            v;
        logic [IW-1:0]   id;
    } vec_t;

    typedef struct {
        string         tag;
        logic [N-1:0]  g;
        logic          v;
        logic [IW-1:0] id;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req = '0;
    logic [N*CW-1:0] quota = '0;
`ifdef ARB_LOCK_EN
    logic            lock = 1'b0;
`endif
    logic [N-1:0]    gnt;
    logic            gnt_valid;
    logic [IW-1:0]   gnt_id;

    int n_checks = 0;
    int n_fail   = 0;

    vec_t vecs[$];
    exp_t sb[$];

    always #5 clk = ~clk;

    arbiter_nq #(.N(N), .CW(CW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .quota     (quota),
`ifdef ARB_LOCK_EN
        .lock      (lock),
`endif
        .gnt       (gnt),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id)
    );

    function automatic logic [N*CW-1:0] q4(input int a3, input int a2, input int a1, input int a0);
        return {CW'(a3), CW'(a2), CW'(a1), CW'(a0)};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input string tag, input logic r, input logic [N-1:0] rq,
                       input logic [N*CW-1:0] q, input logic lk,
                       input logic [N-1:0] g, input logic v, input logic [IW-1:0] id);
        vec_t x;
        x.tag = tag; x.rst = r; x.req = rq; x.quota = q; x.lock = lk;
        x.g = g; x.v = v; x.id = id;
        vecs.push_back(x);
    endtask

    task automatic add_n(input int n, input string tag, input logic [N-1:0] rq,
                         input logic [N*CW-1:0] q, input logic lk,
                         input logic [N-1:0] g, input logic [IW-1:0] id);
        for (int k = 0; k < n; k++) add(tag, 1'b0, rq, q, lk, g, (g != '0), id);
    endtask

    task automatic check_out(input string tag, input logic [N-1:0] g, input logic v,
                             input logic [IW-1:0] id);
        check({tag, ".gnt"},       32'(gnt),       32'(g));
        check({tag, ".gnt_valid"}, 32'(gnt_valid), 32'(v));
        check({tag, ".gnt_id"},    32'(gnt_id),    32'(id));
    endtask

    initial begin
        logic [N*CW-1:0] q3;
        logic [N*CW-1:0] qz;
        logic [N*CW-1:0] q0one;
        logic [N*CW-1:0] q2;
        exp_t e;

        q3    = q4(3, 3, 3, 3);
        qz    = q4(3, 3, 0, 3);
        q0one = q4(3, 3, 3, 1);
        q2    = q4(2, 2, 2, 2);

        // Reset then full contention rotation
        add("rst", 1'b1, 4'b1111, q3, 1'b0, 4'b0000, 1'b0, 2'd0);
        add("rst", 1'b1, 4'b1111, q3, 1'b0, 4'b0000, 1'b0, 2'd0);
        add_n(3, "rot0", 4'b1111, q3, 1'b0, 4'b0001, 2'd0);
        add_n(3, "rot1", 4'b1111, q3, 1'b0, 4'b0010, 2'd1);
        add_n(3, "rot2", 4'b1111, q3, 1'b0, 4'b0100, 2'd2);
        add_n(3, "rot3", 4'b1111, q3, 1'b0, 4'b1000, 2'd3);
        add_n(3, "rot0b", 4'b1111, q3, 1'b0, 4'b0001, 2'd0);
        add_n(1, "rot1b", 4'b1111, q3, 1'b0, 4'b0010, 2'd1);

        // Sole requester, idle hold of gnt_id, pointer after idle
        add("rst", 1'b1, 4'b0100, q3, 1'b0, 4'b0000, 1'b0, 2'd0);
        add_n(10, "sole", 4'b0100, q3, 1'b0, 4'b0100, 2'd2);
        add_n(1, "idle", 4'b0000, q3, 1'b0, 4'b0000, 2'd2);
        add_n(3, "ptr3", 4'b1011, q3, 1'b0, 4'b1000, 2'd3);
        add_n(1, "ptrwrap", 4'b1011, q3, 1'b0, 4'b0001, 2'd0);

        // Holder drop picks RR from h+1
        add("rst", 1'b1, 4'b0010, q3, 1'b0, 4'b0000, 1'b0, 2'd0);
        add_n(1, "drop_h", 4'b0010, q3, 1'b0, 4'b0010, 2'd1);
        add_n(1, "drop_j", 4'b1001, q3, 1'b0, 4'b1000, 2'd3);
        add_n(1, "drop_idle", 4'b0000, q3, 1'b0, 4'b0000, 2'd3);

        // Zero quota acts as one
        add("rst", 1'b1, 4'b0011, qz, 1'b0, 4'b0000, 1'b0, 2'd0);
        add_n(3, "qz0", 4'b0011, qz, 1'b0, 4'b0001, 2'd0);
        add_n(1, "qz1", 4'b0011, qz, 1'b0, 4'b0010, 2'd1);
        add_n(1, "qz0b", 4'b0011, qz, 1'b0, 4'b0001, 2'd0);
        add_n(1, "qz1b", 4'b0011, qz, 1'b0, 4'b0010, 2'd1);

        // Runtime quota lowered while holder has cnt=1
        add("rst", 1'b1, 4'b0011, q3, 1'b0, 4'b0000, 1'b0, 2'd0);
        add_n(2, "rtq_hold", 4'b0011, q3, 1'b0, 4'b0001, 2'd0);
        add_n(1, "rtq_yield", 4'b0011, q0one, 1'b0, 4'b0010, 2'd1);

`ifdef ARB_LOCK_EN
        add("rst", 1'b1, 4'b0011, q2, 1'b0, 4'b0000, 1'b0, 2'd0);
        add_n(6, "lock", 4'b0011, q2, 1'b1, 4'b0001, 2'd0);
        add_n(1, "unlock", 4'b0011, q2, 1'b0, 4'b0010, 2'd1);
`else
        add_n(1, "q2keep", 4'b0011, q2, 1'b0, 4'b0010, 2'd1);
`endif

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            rst   = vecs[i].rst;
            req   = vecs[i].req;
            quota = vecs[i].quota;
`ifdef ARB_LOCK_EN
            lock  = vecs[i].lock;
`endif
            e.tag = $sformatf("%s[%0d]", vecs[i].tag, i);
            e.g   = vecs[i].g;
            e.v   = vecs[i].v;
            e.id  = vecs[i].id;
            sb.push_back(e);
            @(posedge clk);
            #1;
            e = sb.pop_front();
            check_out(e.tag, e.g, e.v, e.id);
        end

        // Trailing grant cycle: no combinational path from req to gnt
        @(negedge clk);
        rst = 1'b1; req = 4'b0010; quota = q3;
`ifdef ARB_LOCK_EN
        lock = 1'b0;
`endif
        @(posedge clk); #1;
        check_out("hs_rst", 4'b0000, 1'b0, 2'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        check_out("hs_grant", 4'b0010, 1'b1, 2'd1);
        @(negedge clk);
        req = 4'b1001;
        #1;
        check_out("hs_trail", 4'b0010, 1'b1, 2'd1);
        @(posedge clk); #1;
        check_out("hs_switch", 4'b1000, 1'b1, 2'd3);

        // Reset overrides a live grant
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check_out("hs_midrst", 4'b0000, 1'b0, 2'd0);
        @(negedge clk);
        rst = 1'b0; req = 4'b1111;
        @(posedge clk); #1;
        check_out("hs_afterrst", 4'b0001, 1'b1, 2'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/arbiter_nq.md
# arbiter_nq

N-requester arbiter for shared-resource access. Each requester has a runtime quota of consecutive grant cycles. While other requesters wait, a holder keeps the grant until its usage counter reaches its quota, then the grant rotates round-robin. This is the parametrised successor of the fixed two-requester cool-down arbiter. It generalises requester count and quota width, adds per-requester runtime quotas, round-robin fairness, a grant index output and an optional lock.

## Interface
- N, 4, number of requesters (2..16)
- CW, 5, width of each quota field and usage counter
- IW, $clog2(N), width of gnt_id (derived)
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous active-high reset
- req  input  N  request vector; bit i = requester i
- quota  input  N*CW  packed per-requester quota; field i = quota[i*CW +: CW]; value 0 treated as 1
- lock  input  1  hold current grant (present only with ARB_LOCK_EN)
- gnt  output  N  registered one-hot grant, or all zero
- gnt_valid  output  1  registered; high when gnt != 0
- gnt_id  output  IW  registered index of the granted requester; holds its last value when idle

## Operation
- State: IDLE or GRANT(h), where h = holder index. Round-robin pointer ptr (IW bits) = index after the last holder, modulo N.
- Effective quota: qe[i] = (quota field i == 0) ? 1 : quota field i.
- Usage counters cnt[i] (CW bits), updated every cycle:
  - gnt[i]=1 and cnt[i] < qe[i]: cnt[i] increments.
  - gnt[i]=0 and cnt[i] > 0: cnt[i] decrements.
  - Otherwise cnt[i] holds; it saturates at both ends with no wrap.
- RR search from s: lowest-distance index j = (s+k) mod N, k = 0..N-1, with req[j]=1, excluding the holder where stated.
- IDLE:
  - No req: stay in IDLE.
  - Otherwise: grant the RR winner from ptr.
- GRANT(h):
  - req[h]=0: grant the RR winner from h+1. If there is none, go to IDLE.
  - req[h]=1 and no other req: keep h, whatever cnt[h] is.
  - req[h]=1 with others requesting and cnt[h] >= qe[h]-1: grant the RR winner from h+1, excluding h.
  - req[h]=1 with others requesting otherwise: keep h.
- On any grant change to j: ptr <= j+1 mod N.
- With no prior use (cnt[h]=0 at grant), a contended holder receives exactly qe[h] consecutive cycles. Recent use (cnt[h]>0) shortens the window accordingly.
- Runtime quota change: quota is sampled every cycle. If quota is lowered below cnt[h], the holder yields on the next contended decision.

## Timing
- Reset values: gnt=0, gnt_valid=0, gnt_id=0, all cnt=0, ptr=0, state IDLE. rst overrides all other inputs, including mid-grant.
- Latency: req sampled at edge t produces gnt at t+1. Outputs are purely registered, with no combinational path from req to gnt.
- When req[h] drops, gnt[h] stays asserted for that one cycle. Requesters must tolerate one trailing grant cycle.
- A grant change takes one edge. There is no gap cycle between holders when another requester is waiting.
- Simultaneous drop of req[h] and rise of req[j]: j is granted on the next edge, selected by RR from h+1.

## Configuration
- ARB_LOCK_EN defined:
  - The lock port exists.
  - In GRANT(h) with lock=1 and req[h]=1, h is kept regardless of quota and other requests.
  - cnt[h] still counts and saturates at qe[h].
  - lock has no effect in IDLE or when req[h]=0.
- ARB_LOCK_EN undefined: no lock port; behaviour is identical to lock=0.

## Test plan
- Reset: rst=1 for 2 cycles with req=4'b1111 -> gnt=0, gnt_valid=0, gnt_id=0 throughout. On the first edge after release, gnt=4'b0001 and gnt_id=0.
- Sole requester: req=4'b0100 for 10 cycles, all quotas 3 -> gnt=4'b0100 from cycle 1 onward with no switch; cnt[2] saturates at 3.
- Contention rotation: N=4, all quotas 3, req=4'b1111 from IDLE -> gnt sequence 0001×3, 0010×3, 0100×3, 1000×3, then 0001×3 again (cnt[0] has decayed to 0).
- Holder drop: holder 1 with req changing to 4'b1001 -> gnt=0010 for one more cycle, then 1000 (RR from index 2 skips 2, picks 3).
- Quota zero and runtime change: quota[1]=0, quota[0]=3, req=4'b0011 -> gnt repeats 0001×3, 0010×1. Changing quota[0] to 1 mid-hold with cnt[0]=1 -> holder 0 yields on the next edge.
- Lock (ARB_LOCK_EN): holder 0, quota 2, req=4'b0011, lock=1 for 6 cycles -> gnt=0001 for all 6 cycles. With lock=0 and cnt[0]>=1, gnt=0010 on the next edge.
